// File: rtl/prf_arb_pkg.sv
// Shared sizing helpers and popcount for the PRF read arbiter slice.
package prf_arb_pkg;

  localparam int unsigned DATA_BITS = 64;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned port_idx_bits(input int unsigned read_ports);
    return idx_bits(read_ports);
  endfunction

  function automatic int unsigned req_idx_bits(input int unsigned req_count);
    return idx_bits(req_count);
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned b = 0; b < 32; b++) begin
      c += 32'(v[b]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prf_read_arbiter_if.sv
// Issue-queue request/response bus plus PRF read side of the arbiter.
interface prf_read_arbiter_if
  import prf_arb_pkg::*;
#(
    parameter int unsigned REQ_COUNT    = 4,
    parameter int unsigned MAX_OPERANDS = 3,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned READ_PORTS   = 6
);
    logic [REQ_COUNT-1:0]                                  req_valid;
    logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0]                req_enable;
    logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  req_prn;
    logic [REQ_COUNT-1:0]                                  req_grant;
    logic [REQ_COUNT-1:0]                                  rsp_valid;
    logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] rsp_data;
    logic [READ_PORTS-1:0]                                 prf_rd_en;
    logic [READ_PORTS-1:0][PRN_BITS-1:0]                   prf_rd_prn;
    logic [READ_PORTS-1:0][DATA_BITS-1:0]                  prf_rd_data;

    modport master (
        output req_valid, req_enable, req_prn, prf_rd_data,
        input  req_grant, rsp_valid, rsp_data, prf_rd_en, prf_rd_prn
    );

    modport slave (
        input  req_valid, req_enable, req_prn, prf_rd_data,
        output req_grant, rsp_valid, rsp_data, prf_rd_en, prf_rd_prn
    );
endinterface

// File: rtl/prf_port_alloc.sv
// Combinational round-robin scan: all-or-nothing grants and lowest-free-port
// assignment of each granted requester's enabled operand slots.
module prf_port_alloc
  import prf_arb_pkg::*;
#(
    parameter int unsigned REQ_COUNT    = 4,
    parameter int unsigned MAX_OPERANDS = 3,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned READ_PORTS   = 6,
    parameter int unsigned PIB          = port_idx_bits(READ_PORTS),
    parameter int unsigned RIB          = req_idx_bits(REQ_COUNT)
) (
    input  logic                                                i_block,
    input  logic [RIB-1:0]                                      i_rr_ptr,
    input  logic [REQ_COUNT-1:0]                                i_req_valid,
    input  logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0]              i_req_enable,
    input  logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] i_req_prn,
    output logic [REQ_COUNT-1:0]                                o_grant,
    output logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0][PIB-1:0]     o_port_map,
    output logic [READ_PORTS-1:0]                               o_rd_en,
    output logic [READ_PORTS-1:0][PRN_BITS-1:0]                 o_rd_prn,
    output logic                                                o_any_grant,
    output logic [RIB-1:0]                                      o_first_idx
);

    always_comb begin
        int unsigned    w_free;
        int unsigned    w_need;
        logic [RIB-1:0] w_idx;
        logic [PIB-1:0] w_port;

        o_grant     = '0;
        o_port_map  = '0;
        o_rd_en     = '0;
        o_rd_prn    = '0;
        o_any_grant = 1'b0;
        o_first_idx = '0;
        w_free      = READ_PORTS;
        w_need      = 0;
        w_idx       = '0;
        w_port      = '0;

        for (int unsigned k = 0; k < REQ_COUNT; k++) begin
            w_idx  = RIB'((32'(i_rr_ptr) + k) % REQ_COUNT);
            w_need = popcount(32'(i_req_enable[w_idx]));
            // Non-fitting requesters are skipped, not blocking later ones.
            if (!i_block && i_req_valid[w_idx] && (w_need <= w_free)) begin
                o_grant[w_idx] = 1'b1;
                w_free         = w_free - w_need;
                if (!o_any_grant) begin
                    o_any_grant = 1'b1;
                    o_first_idx = w_idx;
                end
                for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
                    if (i_req_enable[w_idx][j]) begin
                        o_port_map[w_idx][j] = w_port;
                        o_rd_en[w_port]      = 1'b1;
                        o_rd_prn[w_port]     = i_req_prn[w_idx][j];
                        w_port               = w_port + PIB'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/prf_read_arbiter.sv
// Shares PRF read ports among issue queues; holds the round-robin pointer and
// the one-cycle response pipeline that routes read data back per operand slot.
module prf_read_arbiter
  import prf_arb_pkg::*;
#(
    parameter int unsigned REQ_COUNT    = 4,
    parameter int unsigned MAX_OPERANDS = 3,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned READ_PORTS   = 6
) (
    input  logic               clk,
    input  logic               rst,
    prf_read_arbiter_if.slave  bus
);

    localparam int unsigned PIB = port_idx_bits(READ_PORTS);
    localparam int unsigned RIB = req_idx_bits(REQ_COUNT);

    generate
        if (READ_PORTS < MAX_OPERANDS) begin : g_bad_cfg
            $error("prf_read_arbiter: READ_PORTS must be >= MAX_OPERANDS");
        end
    endgenerate

    logic [RIB-1:0]                                      r_rr_ptr;
    logic [REQ_COUNT-1:0]                                r_grant_q;
    logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0]              r_en_q;
    logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0][PIB-1:0]     r_map_q;

    logic [REQ_COUNT-1:0]                                w_grant;
    logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0][PIB-1:0]     w_port_map;
    logic [READ_PORTS-1:0]                               w_rd_en;
    logic [READ_PORTS-1:0][PRN_BITS-1:0]                 w_rd_prn;
    logic                                                w_any_grant;
    logic [RIB-1:0]                                      w_first_idx;
    logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] w_rsp_data;

    prf_port_alloc #(
        .REQ_COUNT    (REQ_COUNT),
        .MAX_OPERANDS (MAX_OPERANDS),
        .PRN_BITS     (PRN_BITS),
        .READ_PORTS   (READ_PORTS),
        .PIB          (PIB),
        .RIB          (RIB)
    ) u_alloc (
        .i_block      (rst),
        .i_rr_ptr     (r_rr_ptr),
        .i_req_valid  (bus.req_valid),
        .i_req_enable (bus.req_enable),
        .i_req_prn    (bus.req_prn),
        .o_grant      (w_grant),
        .o_port_map   (w_port_map),
        .o_rd_en      (w_rd_en),
        .o_rd_prn     (w_rd_prn),
        .o_any_grant  (w_any_grant),
        .o_first_idx  (w_first_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_grant_q <= '0;
            r_en_q    <= '0;
            r_map_q   <= '0;
        end else begin
            if (w_any_grant) begin
                r_rr_ptr <= RIB'((32'(w_first_idx) + 1) % REQ_COUNT);
            end
            r_grant_q <= w_grant;
            for (int unsigned i = 0; i < REQ_COUNT; i++) begin
                r_en_q[i] <= bus.req_enable[i] & {MAX_OPERANDS{w_grant[i]}};
            end
            r_map_q <= w_port_map;
        end
    end

    always_comb begin
        w_rsp_data = '0;
        for (int unsigned i = 0; i < REQ_COUNT; i++) begin
            for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
                if (r_en_q[i][j]) begin
                    w_rsp_data[i][j] = bus.prf_rd_data[r_map_q[i][j]];
                end
            end
        end
    end

    assign bus.req_grant  = w_grant;
    assign bus.prf_rd_en  = w_rd_en;
    assign bus.prf_rd_prn = w_rd_prn;
    assign bus.rsp_valid  = r_grant_q;
    assign bus.rsp_data   = w_rsp_data;

endmodule
